// File: rtl/seq_pkg.sv
// Shared FSM encodings for the serial pattern detectors in this codebase.
package seq_pkg;

  typedef enum logic [1:0] {
    S0   = 2'd0,
    S1   = 2'd1,
    S10  = 2'd2,
    S100 = 2'd3
  } state_t;

endpackage

// File: rtl/seq_1001_step.sv
// Combinational "1001" Mealy step: (state, bit) -> (next state, hit). Overlapping matches allowed.
module seq_1001_step
  import seq_pkg::*;
(
  input  state_t st,
  input  logic   in_bit,
  output state_t nxt,
  output logic   hit
);

  always_comb begin
    nxt = S0;
    hit = 1'b0;
    case (st)
      S0:   nxt = in_bit ? S1 : S0;
      S1:   nxt = in_bit ? S1 : S10;
      S10:  nxt = in_bit ? S1 : S100;
      S100: begin
        nxt = in_bit ? S1 : S0;
        hit = in_bit;
      end
      default: nxt = S0;
    endcase
  end

endmodule

// File: rtl/seq_1001_mux_ctrl.sv
// Round-robin time-multiplexed "1001" detector over NCH serial channels with per-channel
// saved context and saturating match counters; one bit is consumed per cycle, result registered.
module seq_1001_mux_ctrl
  import seq_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic [NCH-1:0]         req,
  input  logic [NCH-1:0]         din,
  output logic [NCH-1:0]         ack,
  output logic                   det_valid,
  output logic [$clog2(NCH)-1:0] det_ch,
  output logic                   det_out,
  input  logic [$clog2(NCH)-1:0] cnt_sel,
  output logic [CW-1:0]          cnt_rd
);

  localparam int PW = $clog2(NCH);

  state_t          ctx_q [NCH];
  state_t          ctx_d [NCH];
  logic [CW-1:0]   cnt_q [NCH];
  logic [CW-1:0]   cnt_d [NCH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            det_valid_q, det_valid_d;
  logic [PW-1:0]   det_ch_q, det_ch_d;
  logic            det_out_q, det_out_d;

  logic            gnt_vld;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   cand;
  int              s;
  state_t          step_nxt;
  logic            step_hit;

  // Search ptr, ptr+1, ... wrapping; first requester wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    s       = 0;
    for (int k = 0; k < NCH; k++) begin
      s = int'(ptr_q) + k;
      if (s >= NCH) s = s - NCH;
      cand = PW'(s);
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    ack = '0;
    if (gnt_vld && !clr && !rst) ack[gnt_idx] = 1'b1;
  end

  seq_1001_step u_step (
    .st     (ctx_q[gnt_idx]),
    .in_bit (din[gnt_idx]),
    .nxt    (step_nxt),
    .hit    (step_hit)
  );

  always_comb begin
    ctx_d       = ctx_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    det_valid_d = 1'b0;
    det_out_d   = 1'b0;
    det_ch_d    = det_ch_q;
    if (clr) begin
      for (int i = 0; i < NCH; i++) begin
        ctx_d[i] = S0;
        cnt_d[i] = '0;
      end
      ptr_d = '0;
    end else if (gnt_vld) begin
      ctx_d[gnt_idx] = step_nxt;
      ptr_d          = (gnt_idx == PW'(NCH - 1)) ? '0 : gnt_idx + PW'(1);
      det_valid_d    = 1'b1;
      det_ch_d       = gnt_idx;
      det_out_d      = step_hit;
      if (step_hit && (cnt_q[gnt_idx] != {CW{1'b1}}))
        cnt_d[gnt_idx] = cnt_q[gnt_idx] + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        ctx_q[i] <= S0;
        cnt_q[i] <= '0;
      end
      ptr_q       <= '0;
      det_valid_q <= 1'b0;
      det_ch_q    <= '0;
      det_out_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        ctx_q[i] <= ctx_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      ptr_q       <= ptr_d;
      det_valid_q <= det_valid_d;
      det_ch_q    <= det_ch_d;
      det_out_q   <= det_out_d;
    end
  end

  assign det_valid = det_valid_q;
  assign det_ch    = det_ch_q;
  assign det_out   = det_out_q;
  // Pre-edge value by construction: reads the flops, not the next-state.
  assign cnt_rd    = cnt_q[cnt_sel];

endmodule

// File: tb/tb_seq_1001_mux_ctrl.sv
// Table-driven bench with an expected-result queue for seq_1001_mux_ctrl (NCH=4, CW=2).
module tb_seq_1001_mux_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] din = '0;
  logic [3:0] ack;
  logic       det_valid;
  logic [1:0] det_ch;
  logic       det_out;
  logic [1:0] cnt_sel = '0;
  logic [1:0] cnt_rd;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_1001_mux_ctrl #(.NCH(4), .CW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .req       (req),
    .din       (din),
    .ack       (ack),
    .det_valid (det_valid),
    .det_ch    (det_ch),
    .det_out   (det_out),
    .cnt_sel   (cnt_sel),
    .cnt_rd    (cnt_rd)
  );

  typedef struct {
    logic       clr;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] ack;
    logic       hit;
    logic       cchk;
    logic [1:0] csel;
    logic [1:0] cexp;
  } vec_t;

  typedef struct {
    logic       vld;
    logic [1:0] ch;
    logic       hit;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  function automatic vec_t mk(input logic c, input logic [3:0] r, d, a, input logic h,
                              input logic cc = 1'b0, input logic [1:0] cs = 2'd0,
                              input logic [1:0] ce = 2'd0);
    vec_t v;
    v.clr = c; v.req = r; v.din = d; v.ack = a; v.hit = h;
    v.cchk = cc; v.csel = cs; v.cexp = ce;
    return v;
  endfunction

  function automatic logic [1:0] idx_of(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic [3:0] r, d, exp_ack, input logic h,
                       input logic [1:0] sel);
    exp_t e;
    @(negedge clk);
    clr = c; req = r; din = d; cnt_sel = sel;
    #1;
    chk("ack", 32'(ack), 32'(exp_ack));
    e.vld = |exp_ack;
    e.ch  = idx_of(exp_ack);
    e.hit = h & (|exp_ack);
    exp_q.push_back(e);
  endtask

  task automatic edge_chk();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("det_valid", 32'(det_valid), 32'(e.vld));
      if (e.vld) chk("det_ch", 32'(det_ch), 32'(e.ch));
      chk("det_out", 32'(det_out), 32'(e.hit));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Single channel 0, bits 1001001: hits on bits 4 and 7.
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 4'b0001, 0));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0001, 0));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0001, 0));
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 4'b0001, 1, 1, 2'd0, 2'd1));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0001, 0));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0001, 0));
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 4'b0001, 1, 1, 2'd0, 2'd2));
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 0, 1, 2'd0, 2'd0));
    // ch0 sends 1001, ch1 sends 0110, interleaved with each held until acked.
    vecs.push_back(mk(0, 4'b0011, 4'b0001, 4'b0001, 0));
    vecs.push_back(mk(0, 4'b0011, 4'b0000, 4'b0010, 0));
    vecs.push_back(mk(0, 4'b0011, 4'b0010, 4'b0001, 0));
    vecs.push_back(mk(0, 4'b0011, 4'b0010, 4'b0010, 0));
    vecs.push_back(mk(0, 4'b0011, 4'b0010, 4'b0001, 0));
    vecs.push_back(mk(0, 4'b0011, 4'b0011, 4'b0010, 0));
    vecs.push_back(mk(0, 4'b0011, 4'b0001, 4'b0001, 1, 1, 2'd0, 2'd1));
    vecs.push_back(mk(0, 4'b0010, 4'b0000, 4'b0010, 0, 1, 2'd1, 2'd0));
    vecs.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000, 0));
    // All requesting: strict rotation, then sparse request mask.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'(1 << (i % 4)), 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 4'b1010, 4'b0000, (i % 2 == 0) ? 4'b0010 : 4'b1000, 0));

    // Reset state
    req = 4'b1111;
    #2;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_det_valid", 32'(det_valid), 32'd0);
    chk("rst_det_ch", 32'(det_ch), 32'd0);
    chk("rst_det_out", 32'(det_out), 32'd0);
    chk("rst_cnt", 32'(cnt_rd), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req = '0;

    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].req, vecs[i].din, vecs[i].clr ? 4'b0000 : vecs[i].ack,
            vecs[i].hit, vecs[i].csel);
      edge_chk();
      if (vecs[i].cchk) chk($sformatf("cnt%0d_v%0d", vecs[i].csel, i), 32'(cnt_rd),
                            32'(vecs[i].cexp));
    end

    // CW=2 saturation on ch2: 1001 x5, counter 1,2,3,3,3; pre-edge read shows old value.
    drive(1, 4'b0000, 4'b0000, 4'b0000, 0, 2'd2);
    edge_chk();
    for (int i = 0; i < 20; i++) begin
      logic [3:0] pat;
      int         hits;
      pat  = 4'b1001;
      hits = i / 4;
      drive(0, 4'b0100, {1'b0, pat[3 - (i % 4)], 2'b00}, 4'b0100, (i % 4) == 3, 2'd2);
      chk($sformatf("cnt2_pre_%0d", i), 32'(cnt_rd), (hits > 3) ? 32'd3 : 32'(hits));
      edge_chk();
      if ((i % 4) == 3)
        chk($sformatf("cnt2_post_%0d", i), 32'(cnt_rd), (hits + 1 > 3) ? 32'd3 : 32'(hits + 1));
    end

    // Async reset mid-stream discards ch0's "100" prefix.
    drive(0, 4'b0001, 4'b0001, 4'b0001, 0, 2'd0);
    edge_chk();
    drive(0, 4'b0001, 4'b0000, 4'b0001, 0, 2'd0);
    edge_chk();
    drive(0, 4'b0001, 4'b0000, 4'b0001, 0, 2'd0);
    edge_chk();
    @(negedge clk);
    req = 4'b0001;
    #2 rst = 1'b1;
    #1;
    chk("midrst_ack", 32'(ack), 32'd0);
    chk("midrst_det_valid", 32'(det_valid), 32'd0);
    chk("midrst_det_out", 32'(det_out), 32'd0);
    chk("midrst_det_ch", 32'(det_ch), 32'd0);
    req = 4'b0000;
    #1 rst = 1'b0;
    drive(0, 4'b0001, 4'b0001, 4'b0001, 0, 2'd0);
    edge_chk();
    chk("cnt0_after_rst", 32'(cnt_rd), 32'd0);

    // clr beats a pending grant, kills ch1's prefix and restarts the pointer.
    drive(0, 4'b0010, 4'b0010, 4'b0010, 0, 2'd1);
    edge_chk();
    drive(0, 4'b0010, 4'b0000, 4'b0010, 0, 2'd1);
    edge_chk();
    drive(0, 4'b0010, 4'b0000, 4'b0010, 0, 2'd1);
    edge_chk();
    drive(1, 4'b0010, 4'b0010, 4'b0000, 0, 2'd1);
    edge_chk();
    drive(0, 4'b1010, 4'b0010, 4'b0010, 0, 2'd1);
    edge_chk();
    chk("cnt1_after_clr", 32'(cnt_rd), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
